// File: rtl/sb_tx_scheduler.sv
// Arbitrates N_REQ 64-bit sideband messages onto one serializer port, paced by buffer credits.
// Latency: req_valid_i to tx_valid_o 1 cycle; tx_ack_i to req_ack_o/credit decrement 1 cycle.
// Backpressure: holds requesters until ack; no grant at zero credits, while disabled or on ack cycle.
module sb_tx_scheduler #(
   parameter int N_REQ       = 4,
   parameter int BUF_DEPTH   = 4,
   parameter int SLOT_CYCLES = 96,
   parameter int ACK_TIMEOUT = 16,
   parameter int PRIO0       = 1
) (
   input  logic                             clk_800MHz,
   input  logic                             reset,
   input  logic                             sb_enable_i,
   input  logic [N_REQ-1:0]                 req_valid_i,
   input  logic [N_REQ*64-1:0]              req_data_i,
   output logic [N_REQ-1:0]                 req_ack_o,
   output logic [63:0]                      tx_data_o,
   output logic                             tx_valid_o,
   input  logic                             tx_ack_i,
   output logic                             tx_enable_o,
   output logic [$clog2(BUF_DEPTH+1)-1:0]   credits_o,
   output logic                             busy_o,
   output logic                             err_o
);

   localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CRED_W = $clog2(BUF_DEPTH + 1);
   localparam int TMR_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

   localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(BUF_DEPTH);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(SLOT_CYCLES - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 1);

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_WAIT_ACK = 1'b1
   } state_t;

   state_t              state_q,   state_d;
   logic [IDX_W-1:0]    last_q,    last_d;
   logic [IDX_W-1:0]    win_q,     win_d;
   logic [WAIT_W-1:0]   wait_q,    wait_d;
   logic [TMR_W-1:0]    timer_q,   timer_d;
   logic [CRED_W-1:0]   credits_q, credits_d;
   logic [63:0]         tx_data_q, tx_data_d;
   logic                tx_valid_q, tx_valid_d;
   logic [N_REQ-1:0]    req_ack_q, req_ack_d;
   logic                tx_en_q,   tx_en_d;
   logic                busy_q,    busy_d;
   logic                err_q,     err_d;

   logic [IDX_W-1:0]    grant_idx;
   logic [63:0]         grant_dat;
   logic                credit_repl;
   logic                credit_used;

   // Round-robin pick: rotate the request vector so the slot after last_q lands at bit 0,
   // take the lowest set bit, then rotate the offset back into requester numbering.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] vld,
                                                input logic [IDX_W-1:0] last);
      logic [2*N_REQ-1:0] rot;
      int unsigned        base;
      int unsigned        off;
      int unsigned        sum;
      base = int'(last) + 1;
      rot  = {vld, vld} >> base;
      off  = 0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = unsigned'(i);
         end
      end
      sum = base + off;
      if (sum >= unsigned'(N_REQ)) begin
         sum = sum - unsigned'(N_REQ);
      end
      return IDX_W'(sum);
   endfunction

   // Winner selection: requester 0 preempts the rotation when strict priority is enabled.
   always_comb begin
      grant_idx = rr_pick(req_valid_i, last_q);
      if ((PRIO0 != 0) && req_valid_i[0]) begin
         grant_idx = '0;
      end
   end

   // Mux the winner's message out of the flat request data bus.
   always_comb begin
      grant_dat = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (grant_idx == IDX_W'(k)) begin
            grant_dat = req_data_i[k*64 +: 64];
         end
      end
   end

   // Handshake FSM, slot timer and credit bookkeeping.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      win_d       = win_q;
      wait_d      = wait_q;
      timer_d     = timer_q;
      credits_d   = credits_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      req_ack_d   = '0;
      tx_en_d     = sb_enable_i;
      err_d       = err_q;
      credit_repl = 1'b0;
      credit_used = 1'b0;

      // A slot drains every SLOT_CYCLES while any buffer entry is occupied.
      if (credits_q != CRED_MAX) begin
         if (timer_q == TMR_LAST) begin
            timer_d     = '0;
            credit_repl = 1'b1;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end else begin
         timer_d = '0;
      end

      case (state_q)
         S_IDLE: begin
            // Skip the ack cycle: the acked requester still shows req_valid_i there.
            if (sb_enable_i && (|req_valid_i) && (credits_q != '0) && (req_ack_q == '0)) begin
               win_d      = grant_idx;
               tx_data_d  = grant_dat;
               tx_valid_d = 1'b1;
               wait_d     = '0;
               state_d    = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (tx_ack_i) begin
               tx_valid_d       = 1'b0;
               req_ack_d[win_q] = 1'b1;
               credit_used      = 1'b1;
               last_d           = win_q;
               state_d          = S_IDLE;
            end else if (wait_q == WAIT_LAST) begin
               // Abandon the attempt; the requester still holds its request and is retried.
               tx_valid_d = 1'b0;
               err_d      = 1'b1;
               state_d    = S_IDLE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
         end
      endcase

      if (credit_repl && !credit_used) begin
         credits_d = credits_q + 1'b1;
      end else if (credit_used && !credit_repl) begin
         credits_d = credits_q - 1'b1;
      end

      busy_d = (state_d == S_WAIT_ACK) || (credits_d != CRED_MAX);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_800MHz) begin
      if (reset) begin
         state_q    <= S_IDLE;
         last_q     <= IDX_LAST;
         win_q      <= '0;
         wait_q     <= '0;
         timer_q    <= '0;
         credits_q  <= CRED_MAX;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         req_ack_q  <= '0;
         tx_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         win_q      <= win_d;
         wait_q     <= wait_d;
         timer_q    <= timer_d;
         credits_q  <= credits_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         req_ack_q  <= req_ack_d;
         tx_en_q    <= tx_en_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign req_ack_o   = req_ack_q;
   assign tx_data_o   = tx_data_q;
   assign tx_valid_o  = tx_valid_q;
   assign tx_enable_o = tx_en_q;
   assign credits_o   = credits_q;
   assign busy_o      = busy_q;
   assign err_o       = err_q;

   // Credits never exceed the buffer depth.
   a_credit_range: assert property (@(posedge clk_800MHz) disable iff (reset)
      credits_q <= CRED_MAX);

   // At most one requester is acknowledged per cycle.
   a_ack_onehot: assert property (@(posedge clk_800MHz) disable iff (reset)
      $onehot0(req_ack_q));

   // The offered message is stable for the whole handshake.
   a_data_hold: assert property (@(posedge clk_800MHz) disable iff (reset)
      ((state_q == S_WAIT_ACK) && (state_d == S_WAIT_ACK)) |-> (tx_data_d == tx_data_q));

endmodule

// File: tb/tb_sb_tx_scheduler.sv
// Bench for sb_tx_scheduler: strict-priority and round-robin instances under random traffic.
// Every output of both instances is compared each cycle with a message-level reference model.
// Directed phases cover first grant, saturation, ack timeout, reset mid-handshake, disable, idle.
module tb_sb_tx_scheduler;

   localparam int N    = 4;
   localparam int BUF  = 4;
   localparam int SLOT = 96;
   localparam int TO   = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           reset;
   logic           en;
   logic [N-1:0]   rv      [2];
   logic [N*64-1:0] rd     [2];
   logic           ack     [2];
   logic [N-1:0]   req_ack [2];
   logic [63:0]    tx_data [2];
   logic           tx_valid[2];
   logic           tx_en   [2];
   logic [2:0]     credits [2];
   logic           busy    [2];
   logic           err     [2];

   sb_tx_scheduler #(.N_REQ(N), .BUF_DEPTH(BUF), .SLOT_CYCLES(SLOT), .ACK_TIMEOUT(TO), .PRIO0(1)) u_prio (
      .clk_800MHz(clk), .reset(reset), .sb_enable_i(en),
      .req_valid_i(rv[0]), .req_data_i(rd[0]), .req_ack_o(req_ack[0]),
      .tx_data_o(tx_data[0]), .tx_valid_o(tx_valid[0]), .tx_ack_i(ack[0]),
      .tx_enable_o(tx_en[0]), .credits_o(credits[0]), .busy_o(busy[0]), .err_o(err[0]));

   sb_tx_scheduler #(.N_REQ(N), .BUF_DEPTH(BUF), .SLOT_CYCLES(SLOT), .ACK_TIMEOUT(TO), .PRIO0(0)) u_rr (
      .clk_800MHz(clk), .reset(reset), .sb_enable_i(en),
      .req_valid_i(rv[1]), .req_data_i(rd[1]), .req_ack_o(req_ack[1]),
      .tx_data_o(tx_data[1]), .tx_valid_o(tx_valid[1]), .tx_ack_i(ack[1]),
      .tx_enable_o(tx_en[1]), .credits_o(credits[1]), .busy_o(busy[1]), .err_o(err[1]));

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Stimulus controls (written only by the main sequence)
   bit auto_req  = 1'b0;
   int dir_k     = -1;
   int ack_div   = 3;
   bit ack_never = 1'b0;
   bit chk_on    = 1'b0;

   // Requesters: raise a message, hold it until acknowledged, then drop it.
   logic [N-1:0] pend [2];
   initial begin
      for (int d = 0; d < 2; d++) begin
         rv[d] = '0; rd[d] = '0; ack[d] = 1'b0; pend[d] = '0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < N; k++) begin
               if (req_ack[d][k] === 1'b1) begin
                  pend[d][k] = 1'b0;
               end else if (!pend[d][k] && (dir_k == k || (auto_req && $urandom_range(0, 7) == 0))) begin
                  pend[d][k] = 1'b1;
                  rd[d][k*64 +: 64] = (dir_k == k) ? 64'hDEAD_BEEF_0123_4567 : {$urandom, $urandom};
               end
            end
            rv[d]  = pend[d];
            ack[d] = !ack_never && ($urandom_range(0, ack_div - 1) == 0);
         end
      end
   end

   // Reference model: one message in flight at a time, credits tracked as a plain count.
   int           m_cred  [2];
   int           m_timer [2];
   int           m_last  [2];
   int           m_win   [2];
   int           m_wait  [2];
   bit           m_fly   [2];
   bit           m_err   [2];
   bit           m_en    [2];
   logic [63:0]  m_data  [2];
   logic [N-1:0] m_ackp  [2];

   function automatic int pick(input logic [N-1:0] v, input int last, input bit prio);
      if (prio && v[0]) return 0;
      for (int i = 1; i <= N; i++) begin
         if (v[(last + i) % N]) return (last + i) % N;
      end
      return 0;
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         bit           repl;
         bit           used;
         logic [N-1:0] ackn;
         int           w;
         if (reset) begin
            m_cred[d] = BUF; m_timer[d] = 0; m_last[d] = N - 1; m_win[d] = 0; m_wait[d] = 0;
            m_fly[d] = 0; m_err[d] = 0; m_en[d] = 0; m_data[d] = '0; m_ackp[d] = '0;
         end else begin
            repl = (m_cred[d] < BUF) && (m_timer[d] == SLOT - 1);
            if (m_cred[d] < BUF) m_timer[d] = repl ? 0 : m_timer[d] + 1;
            else                 m_timer[d] = 0;
            used = 0;
            ackn = '0;
            if (m_fly[d]) begin
               if (ack[d]) begin
                  used = 1; ackn[m_win[d]] = 1'b1; m_last[d] = m_win[d]; m_fly[d] = 0;
               end else if (m_wait[d] == TO - 1) begin
                  m_err[d] = 1; m_fly[d] = 0;
               end else begin
                  m_wait[d]++;
               end
            end else if (en && rv[d] != 0 && m_cred[d] > 0 && m_ackp[d] == 0) begin
               w = pick(rv[d], m_last[d], d == 0);
               m_win[d] = w; m_data[d] = rd[d][w*64 +: 64]; m_fly[d] = 1; m_wait[d] = 0;
            end
            m_ackp[d] = ackn;
            m_cred[d] = m_cred[d] + int'(repl) - int'(used);
            m_en[d]   = en;
         end
      end
   end

   // Per-cycle comparison of both instances against the model, away from the clock edge.
   always @(negedge clk) begin
      if (chk_on) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d tx_valid", d), tx_valid[d], m_fly[d]);
            if (m_fly[d]) chk($sformatf("d%0d tx_data", d), tx_data[d], m_data[d]);
            chk($sformatf("d%0d req_ack", d), req_ack[d], m_ackp[d]);
            chk($sformatf("d%0d credits", d), credits[d], m_cred[d]);
            chk($sformatf("d%0d busy", d), busy[d], (m_fly[d] || m_cred[d] < BUF));
            chk($sformatf("d%0d err", d), err[d], m_err[d]);
            chk($sformatf("d%0d tx_enable", d), tx_en[d], m_en[d]);
         end
      end
   end

   int cnt;

   initial begin
      reset = 1'b1;
      en    = 1'b0;
      repeat (3) @(negedge clk);
      chk_on = 1'b1;
      for (int d = 0; d < 2; d++) begin
         chk("reset tx_data", tx_data[d], 64'h0);
         chk("reset credits", credits[d], 4);
         chk("reset tx_valid", tx_valid[d], 0);
         chk("reset req_ack", req_ack[d], 0);
         chk("reset busy", busy[d], 0);
      end

      // First grant: requester 2 alone
      reset = 1'b0;
      en    = 1'b1;
      @(negedge clk);
      dir_k = 2;
      @(negedge clk);
      dir_k = -1;
      cnt = 0;
      while (tx_valid[0] !== 1'b1 && cnt < 100) begin @(negedge clk); cnt++; end
      chk("first tx_valid", tx_valid[0], 1);
      chk("first tx_data", tx_data[0], 64'hDEAD_BEEF_0123_4567);
      cnt = 0;
      while (req_ack[0] === '0 && cnt < 100) begin @(negedge clk); cnt++; end
      chk("first req_ack", req_ack[0], 4'b0100);
      chk("first credits", credits[0], 3);

      // Random traffic with occasional enable toggles
      auto_req = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 99) == 0) en = ~en;
      end
      en = 1'b1;

      // Saturation: immediate acks drain all credits
      ack_div = 1;
      repeat (600) @(negedge clk);

      // Ack never arrives: timeouts and sticky error
      ack_never = 1'b1;
      repeat (300) @(negedge clk);
      chk("timeout err prio", err[0], 1);
      chk("timeout err rr", err[1], 1);

      // Reset in the middle of a handshake
      cnt = 0;
      while (tx_valid[0] !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
      chk("pre-reset tx_valid", tx_valid[0], 1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid reset tx_valid", tx_valid[0], 0);
      chk("mid reset credits", credits[0], 4);
      chk("mid reset req_ack", req_ack[0], 0);
      chk("mid reset err", err[0], 0);
      reset = 1'b0;
      ack_never = 1'b0;
      ack_div = 3;
      repeat (200) @(negedge clk);

      // Disabled link with requests pending
      en = 1'b0;
      repeat (20) @(negedge clk);
      cnt = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (tx_valid[0] === 1'b1 || tx_valid[1] === 1'b1) cnt++;
      end
      chk("disabled tx_valid cycles", cnt, 0);
      en = 1'b1;

      // Drain and idle: all credits return
      auto_req = 1'b0;
      repeat (800) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("idle credits", credits[d], 4);
         chk("idle busy", busy[d], 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
